scc_tone_generator_nch: RTL and testbench

- Parametrised successor of the 5-channel SCC tone generator.
- Owns its own time-slot sequencer and presents one channel per slot to the wave RAM and mixer; the register file supplies that slot's frequency combinationally.
- Generalised in channel count, counter and address widths, and in which channels emulate the SCC wave-update error.
- Adds per-channel one-shot playback, a done flag and a stall input.

---
 rtl/scc_tone_generator_nch.sv | 137 +++++++++++++
 tb/tb_scc_tone_generator_nch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_tone_generator_nch.sv
// scc_tone_generator_nch
// Time-slotted N-channel SCC-style tone generator. A free-running slot
// sequencer visits one channel per clock; the visited channel's frequency
// counter, wave address and update-error accumulator are advanced using the
// frequency the register file presents for that slot. Channels may play
// their wave once (one-shot) and then park with a done flag.
module scc_tone_generator_nch #(
    parameter int          CHANNELS   = 5,
    parameter int          SLOTS      = 8,
    parameter int          SLOT_BITS  = 3,
    parameter int          FREQ_BITS  = 12,
    parameter int          ADDR_BITS  = 5,
    parameter int          MIN_PERIOD = 9,
    parameter logic [15:0] ERR_MASK   = 16'b0000_0000_0001_1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [SLOT_BITS-1:0] slot,
    output logic                 slot_valid,
    input  logic [FREQ_BITS-1:0] reg_frequency_count,
    input  logic                 reg_oneshot,
    input  logic                 reg_wave_reset,
    input  logic                 reg_wave_error_en,
    input  logic [CHANNELS-1:0]  clear_counter,
    output logic [ADDR_BITS-1:0] wave_address,
    output logic                 wave_update,
    output logic [CHANNELS-1:0]  channel_done
);

    localparam logic [SLOT_BITS-1:0] LP_LAST_SLOT = SLOT_BITS'(SLOTS - 1);

    // Per-channel state
    logic [SLOT_BITS-1:0] r_slot;
    logic [FREQ_BITS-1:0] r_cnt  [CHANNELS];
    logic [ADDR_BITS-1:0] r_addr [CHANNELS];
    logic [4:0]           r_err  [CHANNELS];
    logic [CHANNELS-1:0]  r_done;

    // State of the channel owning the current slot
    logic                 w_hit;
    logic [FREQ_BITS-1:0] w_cnt;
    logic [ADDR_BITS-1:0] w_addr;
    logic [4:0]           w_err;
    logic                 w_done_cur;
    logic                 w_mask_cur;

    logic                 w_freq_ok;
    logic                 w_step;
    logic                 w_end;
    logic [5:0]           w_sum;
    logic                 w_suppress;
    logic                 w_addr_wrap;

    // Update-error accumulator step: the carry out of bit 4 marks a lost update
    function automatic logic [5:0] f_err_sum(input logic [4:0]           err,
                                             input logic [FREQ_BITS-1:0] freq);
        logic [5:0] sum;
        if (freq[FREQ_BITS-1:5] == '0)
            sum = {1'b0, err} + {1'b0, ~freq[4:0]};
        else if (!freq[0])
            sum = {1'b0, err} + 6'd16;
        else
            sum = 6'd0;
        return sum;
    endfunction

    // Select the registered state of the channel mapped to the current slot
    always_comb begin
        w_hit      = 1'b0;
        w_cnt      = '0;
        w_addr     = '0;
        w_err      = '0;
        w_done_cur = 1'b0;
        w_mask_cur = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_slot == SLOT_BITS'(c)) begin
                w_hit      = 1'b1;
                w_cnt      = r_cnt[c];
                w_addr     = r_addr[c];
                w_err      = r_err[c];
                w_done_cur = r_done[c];
                w_mask_cur = ERR_MASK[c];
            end
        end
    end

    assign w_freq_ok   = (reg_frequency_count >= FREQ_BITS'(MIN_PERIOD));
    assign w_step      = enable && w_hit && !w_done_cur;
    assign w_end       = w_step && (w_cnt == reg_frequency_count) && w_freq_ok;
    assign w_sum       = f_err_sum(w_err, reg_frequency_count);
    assign w_suppress  = w_mask_cur && reg_wave_error_en && w_sum[5];
    assign w_addr_wrap = (w_addr == '1);

    assign slot         = r_slot;
    assign slot_valid   = w_hit;
    assign wave_address = w_addr;
    assign wave_update  = w_end && !w_suppress;
    assign channel_done = r_done;

    // Slot sequencer: one slot per enabled clock, wrapping at the frame end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_slot <= '0;
        else if (enable)
            r_slot <= (r_slot == LP_LAST_SLOT) ? '0 : r_slot + SLOT_BITS'(1);
    end

    // Channel state: clear strobes win over the slot update of the same channel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt[c]  <= '0;
                r_addr[c] <= '0;
                r_err[c]  <= '0;
            end
            r_done <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (clear_counter[c]) begin
                    r_cnt[c]  <= '0;
                    r_done[c] <= 1'b0;
                    if (reg_wave_reset)
                        r_addr[c] <= '0;
                end else if (w_step && (r_slot == SLOT_BITS'(c))) begin
                    r_cnt[c]  <= w_end ? '0 : r_cnt[c] + FREQ_BITS'(1);
                    r_addr[c] <= r_addr[c] + ADDR_BITS'(w_end);
                    if (ERR_MASK[c])
                        r_err[c] <= w_sum[4:0];
                    if (w_end && reg_oneshot && w_addr_wrap)
                        r_done[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scc_tone_generator_nch.sv
// Bench for scc_tone_generator_nch: a per-channel behavioural model tracks
// counts, addresses, error accumulators and done flags as plain integers and
// the DUT outputs are compared against it every clock.
module tb_scc_tone_generator_nch;

    localparam int          CH   = 5;
    localparam int          SL   = 8;
    localparam int          SB   = 3;
    localparam int          FB   = 12;
    localparam int          AB   = 5;
    localparam int          MP   = 9;
    localparam logic [15:0] MASK = 16'b0000_0000_0001_1000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [SB-1:0] slot;
    logic          slot_valid;
    logic [FB-1:0] reg_frequency_count = '0;
    logic          reg_oneshot = 1'b0;
    logic          reg_wave_reset = 1'b0;
    logic          reg_wave_error_en = 1'b0;
    logic [CH-1:0] clear_counter = '0;
    logic [AB-1:0] wave_address;
    logic          wave_update;
    logic [CH-1:0] channel_done;

    scc_tone_generator_nch #(
        .CHANNELS(CH), .SLOTS(SL), .SLOT_BITS(SB), .FREQ_BITS(FB),
        .ADDR_BITS(AB), .MIN_PERIOD(MP), .ERR_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .slot(slot),
        .slot_valid(slot_valid), .reg_frequency_count(reg_frequency_count),
        .reg_oneshot(reg_oneshot), .reg_wave_reset(reg_wave_reset),
        .reg_wave_error_en(reg_wave_error_en), .clear_counter(clear_counter),
        .wave_address(wave_address), .wave_update(wave_update),
        .channel_done(channel_done)
    );

    always #5 clk = ~clk;

    // Model state
    int m_slot;
    int m_cnt  [CH];
    int m_addr [CH];
    int m_err  [CH];
    bit m_done [CH];

    // Stimulus controls
    int            freqs    [CH];
    bit            oneshots [CH];
    bit            t_en, t_errn, t_wr;
    logic [CH-1:0] t_clr;

    // Bookkeeping
    int            tests = 0;
    int            fails = 0;
    int            upd_cnt [CH];
    int            s_slot, s_addr;
    logic [CH-1:0] s_done;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int err_sum(input int err, input int f);
        if (f < 32)          return err + (31 - (f % 32));
        else if (f % 2 == 0) return err + 16;
        else                 return 0;
    endfunction

    function automatic bit is_end(input int c);
        return t_en && !m_done[c] && (m_cnt[c] == freqs[c]) && (freqs[c] >= MP);
    endfunction

    // One clock: drive inputs, compare outputs against the model, advance the model
    task automatic cyc();
        bit            valid;
        bit            e_upd;
        int            e_addr;
        int            sum;
        logic [CH-1:0] e_done;
        @(negedge clk);
        enable            = t_en;
        clear_counter     = t_clr;
        reg_wave_reset    = t_wr;
        reg_wave_error_en = t_errn;
        valid = (m_slot < CH);
        if (valid) begin
            reg_frequency_count = FB'(freqs[m_slot]);
            reg_oneshot         = oneshots[m_slot];
        end else begin
            reg_frequency_count = FB'($urandom);
            reg_oneshot         = 1'($urandom);
        end
        #1;
        e_upd  = 1'b0;
        e_addr = 0;
        if (valid) begin
            sum    = err_sum(m_err[m_slot], freqs[m_slot]);
            e_upd  = is_end(m_slot) && !(MASK[m_slot] && t_errn && sum >= 32);
            e_addr = m_addr[m_slot];
        end
        for (int c = 0; c < CH; c++) e_done[c] = m_done[c];
        check("slot", int'(slot), m_slot);
        check("slot_valid", int'(slot_valid), int'(valid));
        check("wave_address", int'(wave_address), e_addr);
        check("wave_update", int'(wave_update), int'(e_upd));
        check("channel_done", int'(channel_done), int'(e_done));
        s_slot = int'(slot);
        s_addr = int'(wave_address);
        s_done = channel_done;
        if (wave_update && int'(slot) < CH) upd_cnt[slot]++;
        // model advance
        for (int c = 0; c < CH; c++) begin
            if (t_clr[c]) begin
                m_cnt[c]  = 0;
                m_done[c] = 1'b0;
                if (t_wr) m_addr[c] = 0;
            end else if (t_en && valid && c == m_slot && !m_done[c]) begin
                sum = err_sum(m_err[c], freqs[c]);
                if (is_end(c)) begin
                    if (oneshots[c] && m_addr[c] == 31) m_done[c] = 1'b1;
                    m_cnt[c]  = 0;
                    m_addr[c] = (m_addr[c] + 1) % 32;
                end else begin
                    m_cnt[c] = (m_cnt[c] + 1) % 4096;
                end
                if (MASK[c]) m_err[c] = sum % 32;
            end
        end
        if (t_en) m_slot = (m_slot + 1) % SL;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Run until the model reaches slot s, then run that slot's cycle
    task automatic run_to_slot(input int s);
        int guard = 0;
        while (m_slot != s && guard < SL) begin
            cyc();
            guard++;
        end
        cyc();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_slot = 0;
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_addr[c] = 0; m_err[c] = 0; m_done[c] = 1'b0;
            upd_cnt[c] = 0;
        end
        check("rst_slot", int'(slot), 0);
        check("rst_valid", int'(slot_valid), 1);
        check("rst_addr", int'(wave_address), 0);
        check("rst_update", int'(wave_update), 0);
        check("rst_done", int'(channel_done), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Pulse a clear on channel ch in the very cycle that channel reaches its end
    task automatic clear_at_end(input int ch, input bit wr);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_slot == ch && m_cnt[ch] == freqs[ch] && !m_done[ch]) begin
                t_clr = CH'(1 << ch);
                t_wr  = wr;
                cyc();
                t_clr = '0;
                t_wr  = 1'b0;
                found = 1'b1;
            end else begin
                cyc();
            end
        end
        check("clear_at_end_reached", int'(found), 1);
    endtask

    function automatic int total_upd();
        int t = 0;
        for (int c = 0; c < CH; c++) t += upd_cnt[c];
        return t;
    endfunction

    task automatic set_all(input int f, input bit os);
        for (int c = 0; c < CH; c++) begin
            freqs[c]    = f;
            oneshots[c] = os;
        end
    endtask

    function automatic int pick_freq();
        int r = int'($urandom % 8);
        if (r == 0)      return int'($urandom_range(0, 8));
        else if (r == 1) return int'($urandom_range(32, 200));
        else             return int'($urandom_range(9, 14));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t_en = 1'b1; t_errn = 1'b0; t_wr = 1'b0; t_clr = '0;
        set_all(9, 1'b0);

        // Basic stepping at the minimum period
        do_reset();
        run(80);
        check("freq9_updates_80clk", total_upd(), 5);
        cyc();
        check("freq9_ch0_addr", s_addr, 1);

        // Below minimum period: counters free-run, addresses frozen
        set_all(8, 1'b0);
        for (int c = 0; c < CH; c++) upd_cnt[c] = 0;
        run(8000);
        check("freq8_no_updates", total_upd(), 0);
        run_to_slot(0);
        check("freq8_ch0_addr_frozen", s_addr, 1);

        // Update-error emulation on masked channels
        set_all(20, 1'b0);
        t_errn = 1'b1;
        do_reset();
        run(168);
        check("err_ch3_first_end_suppressed", upd_cnt[3], 0);
        check("err_ch0_unmasked_updates", upd_cnt[0], 1);
        run_to_slot(3);
        check("err_ch3_addr_advanced", s_addr, 1);
        run(400);
        t_errn = 1'b0;
        run(400);

        // One-shot playback and restart by clear
        set_all(9, 1'b0);
        oneshots[0] = 1'b1;
        do_reset();
        run(2640);
        check("oneshot_done", int'(s_done[0]), 1);
        check("oneshot_updates", upd_cnt[0], 32);
        run_to_slot(0);
        check("oneshot_addr", s_addr, 0);
        t_clr = 5'b00001;
        cyc();
        t_clr = '0;
        cyc();
        check("oneshot_cleared", int'(s_done[0]), 0);
        run(90);
        check("oneshot_restart", upd_cnt[0], 33);

        // Clear colliding with an end on channel 2
        set_all(9, 1'b0);
        do_reset();
        run(81);
        clear_at_end(2, 1'b0);
        run_to_slot(2);
        check("clr_keep_addr", s_addr, 1);
        clear_at_end(2, 1'b1);
        run_to_slot(2);
        check("clr_zero_addr", s_addr, 0);

        // Stall mid-frame, then reset mid-frame
        run(3);
        t_en = 1'b0;
        run(50);
        t_en = 1'b1;
        run(5);
        do_reset();
        run(20);

        // Randomised traffic
        for (int i = 0; i < 20000; i++) begin
            if (i % 256 == 0) begin
                for (int c = 0; c < CH; c++) begin
                    freqs[c]    = pick_freq();
                    oneshots[c] = 1'($urandom % 2);
                end
                t_errn = 1'($urandom % 2);
            end
            if (i == 10000) do_reset();
            t_en  = (($urandom % 10) != 0);
            t_clr = (($urandom % 32) == 0) ? CH'($urandom) : '0;
            t_wr  = 1'($urandom % 2);
            cyc();
        end
        t_clr = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
